// File: rtl/pattern_pkg.sv
// Shared types and pattern constants for the 4-phase symmetric pattern sequencer.
package pattern_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam logic [7:0] PAT0 = 8'h81;
    localparam logic [7:0] PAT1 = 8'h42;
    localparam logic [7:0] PAT2 = 8'h24;
    localparam logic [7:0] PAT3 = 8'h18;

    function automatic logic [7:0] phase_to_pattern(input logic [1:0] ph);
        logic [7:0] pat;
        case (ph)
            2'd0:    pat = PAT0;
            2'd1:    pat = PAT1;
            2'd2:    pat = PAT2;
            default: pat = PAT3;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/pattern_dwell_timer.sv
// Per-phase dwell down-counter: reloads on load, counts down on en, flags zero.
module pattern_dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic               load,
    input  logic               en,
    input  logic [DWELL_W-1:0] load_val,
    output logic               zero
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pattern_step_controller.sv
// Run/pause/step sequencer with dwell timing and phase preload for the 4-phase pattern generator.
module pattern_step_controller
    import pattern_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic               start,
    input  logic               stop,
    input  logic               step,
    input  logic               dir,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               cfg_valid,
    input  logic [1:0]         cfg_phase,
    output logic               cfg_ready,
    output logic               busy,
    output logic [1:0]         phase,
    output logic [7:0]         pattern,
    output logic               phase_adv,
    output logic               wrap
);

    state_e     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic       adv_q, adv_d;
    logic       wrap_q, wrap_d;
    logic       tmr_load, tmr_en, tmr_zero;
    logic [1:0] next_phase;
    logic       next_wraps;

    pattern_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk      (clk),
        .clear_n  (clear_n),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (dwell),
        .zero     (tmr_zero)
    );

    // Phase arithmetic is modulo 4, so the 2-bit add/subtract wraps naturally.
    assign next_phase = dir ? (phase_q - 2'd1) : (phase_q + 2'd1);
    assign next_wraps = dir ? (phase_q == 2'd0) : (phase_q == 2'd3);

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        adv_d    = 1'b0;
        wrap_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    phase_d = cfg_phase;
                end else if (start && !stop) begin
                    state_d  = RUN;
                    tmr_load = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = PAUSE;
                end else if (tmr_zero) begin
                    phase_d  = next_phase;
                    adv_d    = 1'b1;
                    wrap_d   = next_wraps;
                    tmr_load = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_d = IDLE;
                    phase_d = 2'd0;
                end else if (cfg_valid) begin
                    phase_d = cfg_phase;
                end else if (start) begin
                    state_d  = RUN;
                    tmr_load = 1'b1;
                end else if (step) begin
                    phase_d = next_phase;
                    adv_d   = 1'b1;
                    wrap_d  = next_wraps;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            phase_q <= 2'd0;
            adv_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            adv_q   <= adv_d;
            wrap_q  <= wrap_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign cfg_ready = (state_q == IDLE) || (state_q == PAUSE);
    assign phase     = phase_q;
    assign pattern   = phase_to_pattern(phase_q);
    assign phase_adv = adv_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_pattern_step_controller.sv
// Self-checking bench for pattern_step_controller against a behavioural reference model.
module tb_pattern_step_controller;

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, step = 1'b0, dir = 1'b0;
    logic [7:0] dwell = 8'd0;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_phase = 2'd0;
    logic       cfg_ready, busy, phase_adv, wrap;
    logic [1:0] phase;
    logic [7:0] pattern;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode 0=idle, 1=run, 2=pause
    int m_mode, m_phase, m_cnt;
    bit m_adv, m_wrap;
    logic [7:0] pat_tab [4] = '{8'h81, 8'h42, 8'h24, 8'h18};

    pattern_step_controller #(.DWELL_W(8)) dut (
        .clk(clk), .clear_n(clear_n), .start(start), .stop(stop), .step(step),
        .dir(dir), .dwell(dwell), .cfg_valid(cfg_valid), .cfg_phase(cfg_phase),
        .cfg_ready(cfg_ready), .busy(busy), .phase(phase), .pattern(pattern),
        .phase_adv(phase_adv), .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_mode = 0; m_phase = 0; m_cnt = 0; m_adv = 0; m_wrap = 0;
    endfunction

    function automatic void model_advance();
        int np;
        np = dir ? m_phase - 1 : m_phase + 1;
        m_adv  = 1;
        m_wrap = (np < 0) || (np > 3);
        m_phase = (np + 4) % 4;
    endfunction

    function automatic void model_edge();
        m_adv = 0; m_wrap = 0;
        case (m_mode)
            0: begin
                if (cfg_valid) m_phase = int'(cfg_phase);
                else if (start && !stop) begin m_mode = 1; m_cnt = int'(dwell); end
            end
            1: begin
                if (stop) m_mode = 2;
                else if (m_cnt == 0) begin model_advance(); m_cnt = int'(dwell); end
                else m_cnt = m_cnt - 1;
            end
            default: begin
                if (stop) begin m_mode = 0; m_phase = 0; end
                else if (cfg_valid) m_phase = int'(cfg_phase);
                else if (start) begin m_mode = 1; m_cnt = int'(dwell); end
                else if (step) model_advance();
            end
        endcase
    endfunction

    function automatic logic [13:0] exp_vec();
        return {m_mode == 1, m_mode != 1, 2'(m_phase), pat_tab[m_phase], m_adv, m_wrap};
    endfunction

    function automatic logic [13:0] obs_vec();
        return {busy, cfg_ready, phase, pattern, phase_adv, wrap};
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; step = 0; cfg_valid = 0; cfg_phase = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        clear_n = 0;
        model_reset();
        @(negedge clk);
        clear_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if ({busy, cfg_ready, phase, pattern, phase_adv, wrap} !== {1'b0, 1'b1, 2'd0, 8'h81, 1'b0, 1'b0})
            $display("FAIL reset_state actual=%h required=%h", obs_vec(), {1'b0, 1'b1, 2'd0, 8'h81, 2'b00});
        else n_pass++;
        // Run with dwell=2 long enough to leave phase 0, then reset between edges
        dwell = 2; dir = 0; start = 1;
        cyc();
        start = 0;
        repeat (5) cyc();
        n_checks++;
        if (phase !== 2'd1 || busy !== 1'b1)
            $display("FAIL reset_prerun actual=phase%0d busy%0d required=phase1 busy1", phase, busy);
        else n_pass++;
        #2 clear_n = 0;
        model_reset();
        #1;
        n_checks++;
        if ({busy, cfg_ready, phase, pattern} !== {1'b0, 1'b1, 2'd0, 8'h81})
            $display("FAIL reset_async actual=%h required=%h", {busy, cfg_ready, phase, pattern}, {2'b01, 2'd0, 8'h81});
        else n_pass++;
        @(negedge clk);
        clear_n = 1;
    endtask

    task automatic test_run_up();
        logic [7:0] seq [5] = '{8'h42, 8'h24, 8'h18, 8'h81, 8'h42};
        do_reset();
        dwell = 0; dir = 0; start = 1;
        cyc();
        start = 0;
        n_checks++;
        if (busy !== 1'b1 || pattern !== 8'h81)
            $display("FAIL run_up_enter actual=busy%0d pat%h required=busy1 pat81", busy, pattern);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_checks++;
            if (pattern !== seq[i] || phase_adv !== 1'b1 || wrap !== (i == 3))
                $display("FAIL run_up_step%0d actual=pat%h adv%0d wrap%0d required=pat%h adv1 wrap%0d",
                         i, pattern, phase_adv, wrap, seq[i], (i == 3));
            else n_pass++;
        end
    endtask

    task automatic test_run_down();
        logic [7:0] seq [4] = '{8'h18, 8'h24, 8'h42, 8'h81};
        do_reset();
        dwell = 3; dir = 1; start = 1;
        cyc();
        start = 0;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 4; c++) begin
                cyc();
                n_checks++;
                if (obs_vec() !== exp_vec())
                    $display("FAIL run_down_model p%0d c%0d actual=%h required=%h", p, c, obs_vec(), exp_vec());
                else n_pass++;
            end
            n_checks++;
            if (pattern !== seq[p] || phase_adv !== 1'b1 || wrap !== (p == 0))
                $display("FAIL run_down_phase%0d actual=pat%h adv%0d wrap%0d required=pat%h adv1 wrap%0d",
                         p, pattern, phase_adv, wrap, seq[p], (p == 0));
            else n_pass++;
        end
    endtask

    task automatic test_pause_step();
        do_reset();
        dwell = 1; dir = 0; start = 1;
        cyc();
        start = 0;
        repeat (3) cyc();
        stop = 1;
        cyc();
        stop = 0;
        n_checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1 || phase !== 2'd1 || phase_adv !== 1'b0)
            $display("FAIL pause_enter actual=busy%0d rdy%0d phase%0d adv%0d required=busy0 rdy1 phase1 adv0",
                     busy, cfg_ready, phase, phase_adv);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            step = 1;
            cyc();
            n_checks++;
            if (phase !== 2'(2 + i) || phase_adv !== 1'b1)
                $display("FAIL pause_step%0d actual=phase%0d adv%0d required=phase%0d adv1", i, phase, phase_adv, 2 + i);
            else n_pass++;
            step = 0;
            cyc();
            n_checks++;
            if (phase !== 2'(2 + i) || phase_adv !== 1'b0)
                $display("FAIL pause_hold%0d actual=phase%0d adv%0d required=phase%0d adv0", i, phase, phase_adv, 2 + i);
            else n_pass++;
        end
    endtask

    task automatic test_preload();
        do_reset();
        cfg_valid = 1; cfg_phase = 2;
        #1;
        n_checks++;
        if (cfg_ready !== 1'b1)
            $display("FAIL preload_ready actual=%0d required=1", cfg_ready);
        else n_pass++;
        cyc();
        cfg_valid = 0;
        n_checks++;
        if (phase !== 2'd2 || pattern !== 8'h24 || phase_adv !== 1'b0)
            $display("FAIL preload_idle actual=phase%0d pat%h required=phase2 pat24", phase, pattern);
        else n_pass++;
        dwell = 10; start = 1;
        cyc();
        start = 0; cfg_valid = 1; cfg_phase = 1;
        cyc();
        cfg_valid = 0;
        n_checks++;
        if (phase !== 2'd2 || busy !== 1'b1 || cfg_ready !== 1'b0)
            $display("FAIL preload_run actual=phase%0d busy%0d rdy%0d required=phase2 busy1 rdy0", phase, busy, cfg_ready);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        dwell = 5; start = 1; stop = 1;
        cyc();
        n_checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1)
            $display("FAIL simul_start_stop actual=busy%0d rdy%0d required=busy0 rdy1", busy, cfg_ready);
        else n_pass++;
        stop = 0; start = 0; cfg_valid = 1; cfg_phase = 3;
        cyc();
        cfg_valid = 0; start = 1;
        cyc();
        start = 0; stop = 1;
        cyc();
        cfg_valid = 1; cfg_phase = 2;
        cyc();
        stop = 0; cfg_valid = 0;
        n_checks++;
        if (busy !== 1'b0 || phase !== 2'd0 || pattern !== 8'h81)
            $display("FAIL simul_stop_cfg actual=busy%0d phase%0d pat%h required=busy0 phase0 pat81", busy, phase, pattern);
        else n_pass++;
        start = 1;
        cyc();
        start = 0; stop = 1;
        cyc();
        stop = 0; cfg_valid = 1; cfg_phase = 1; step = 1; dir = 0;
        cyc();
        cfg_valid = 0; step = 0;
        n_checks++;
        if (phase !== 2'd1 || phase_adv !== 1'b0 || cfg_ready !== 1'b1)
            $display("FAIL simul_cfg_step actual=phase%0d adv%0d rdy%0d required=phase1 adv0 rdy1", phase, phase_adv, cfg_ready);
        else n_pass++;
        n_checks++;
        if (obs_vec() !== exp_vec())
            $display("FAIL simul_model actual=%h required=%h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            start     = ($urandom_range(0, 5) == 0);
            stop      = ($urandom_range(0, 9) == 0);
            step      = ($urandom_range(0, 2) == 0);
            dir       = ($urandom_range(0, 3) == 0) ? ~dir : dir;
            dwell     = 8'($urandom_range(0, 3));
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_phase = 2'($urandom_range(0, 3));
            cyc();
            n_checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL random_cycle%0d actual=%h required=%h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_run_up();
        test_run_down();
        test_pause_step();
        test_preload();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
